// File: rtl/vdp_script_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | vdp_script_pkg                                                       |
// | Shared opcodes, VDP port numbers and state encodings for the script  |
// | player and its bus writer.                                           |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package vdp_script_pkg;

  // Script opcodes (first byte of every command)
  localparam logic [7:0] OP_END  = 8'h00;
  localparam logic [7:0] OP_REG  = 8'h01;
  localparam logic [7:0] OP_PAL  = 8'h02;
  localparam logic [7:0] OP_ADDR = 8'h03;
  localparam logic [7:0] OP_DATA = 8'h04;
  localparam logic [7:0] OP_PORT = 8'h05;
  localparam logic [7:0] OP_WAIT = 8'h06;

  // VDP CPU bus port numbers
  localparam logic [1:0] VDP_PORT0 = 2'd0;  // VRAM data
  localparam logic [1:0] VDP_PORT1 = 2'd1;  // control
  localparam logic [1:0] VDP_PORT2 = 2'd2;  // palette
  localparam logic [1:0] VDP_PORT3 = 2'd3;  // indirect

  // Fetch/decode sequencer states
  typedef enum logic [2:0] {
    S_SDRAM = 3'd0,
    S_IDLE  = 3'd1,
    S_FETCH = 3'd2,
    S_CAPT  = 3'd3,
    S_WRITE = 3'd4,
    S_BUSW  = 3'd5,
    S_WAIT  = 3'd6
  } state_t;

  // Bus handshake states
  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_REQ  = 2'd1,
    W_ACK  = 2'd2,
    W_GAP  = 2'd3
  } wstate_t;

endpackage
`default_nettype wire

// File: rtl/vdp_script_player_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | vdp_script_player_if                                                 |
// | Write-only VDP CPU bus: request/acknowledge plus port and data.      |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
interface vdp_script_player_if;
  logic       req;
  logic       ack;
  logic       wr;
  logic [1:0] address;
  logic [7:0] wdata;

  modport master (output req, output wr, output address, output wdata, input ack);
  modport slave  (input req, input wr, input address, input wdata, output ack);
endinterface
`default_nettype wire

// File: rtl/vdp_bus_writer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | vdp_bus_writer                                                       |
// | One VDP bus write per go pulse: request, wait for ack, then hold off |
// | for a port-dependent idle gap and until ack has dropped.             |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module vdp_bus_writer
  import vdp_script_pkg::*;
#(
  parameter int GAP_W    = 10,
  parameter int REG_GAP  = 24,
  parameter int DATA_GAP = 1023
) (
  input  logic       clk,
  input  logic       n_reset,
  input  logic       enable,
  input  logic       go,
  input  logic [1:0] port,
  input  logic [7:0] data,
  input  logic       is_data,
  output logic       ready,
  vdp_script_player_if.master bus
);

  wstate_t          state, state_n;
  logic [GAP_W-1:0] gap, gap_n;
  logic             bus_req, bus_req_n;
  logic [1:0]       bus_port, bus_port_n;
  logic [7:0]       bus_byte, bus_byte_n;
  logic             port0_acc, port0_acc_n;

  // Handshake registers; everything freezes while enable is low
  always_ff @(posedge clk) begin
    if (!n_reset) begin
      state     <= W_IDLE;
      gap       <= '0;
      bus_req   <= 1'b0;
      bus_port  <= 2'd0;
      bus_byte  <= 8'd0;
      port0_acc <= 1'b0;
    end else if (enable) begin
      state     <= state_n;
      gap       <= gap_n;
      bus_req   <= bus_req_n;
      bus_port  <= bus_port_n;
      bus_byte  <= bus_byte_n;
      port0_acc <= port0_acc_n;
    end
  end

  // Next-state: launch, wait for ack, then count the gap and wait for ack low
  always_comb begin
    state_n     = state;
    gap_n       = gap;
    bus_req_n   = bus_req;
    bus_port_n  = bus_port;
    bus_byte_n  = bus_byte;
    port0_acc_n = port0_acc;
    case (state)
      W_IDLE: begin
        if (go) begin
          state_n     = W_REQ;
          bus_req_n   = 1'b1;
          bus_port_n  = port;
          bus_byte_n  = data;
          port0_acc_n = is_data;
        end
      end
      W_REQ: state_n = W_ACK;
      W_ACK: begin
        if (bus.ack) begin
          state_n   = W_GAP;
          bus_req_n = 1'b0;
          gap_n     = port0_acc ? GAP_W'(DATA_GAP) : GAP_W'(REG_GAP);
        end
      end
      W_GAP: begin
        if (gap != '0) begin
          gap_n = gap - 1'b1;
        end else if (!bus.ack) begin
          state_n = W_IDLE;
        end
      end
      default: state_n = W_IDLE;
    endcase
  end

  // Write-only master: wr simply follows req
  assign bus.req     = bus_req;
  assign bus.wr      = bus_req;
  assign bus.address = bus_port;
  assign bus.wdata   = bus_byte;
  assign ready       = (state == W_IDLE);

endmodule
`default_nettype wire

// File: rtl/vdp_script_player.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | vdp_script_player                                                    |
// | Fetches a byte-coded VDP init script from a synchronous ROM and      |
// | replays it as VDP bus writes, palette loads, VRAM loads and waits.   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module vdp_script_player
  import vdp_script_pkg::*;
#(
  parameter int ROM_AW   = 14,
  parameter int GAP_W    = 10,
  parameter int REG_GAP  = 24,
  parameter int DATA_GAP = 1023
) (
  input  logic              clk,
  input  logic              n_reset,
  input  logic              start,
  input  logic              enable,
  input  logic              sdram_busy,
  vdp_script_player_if.master bus,
  output logic [ROM_AW-1:0] rom_address,
  input  logic [7:0]        rom_data,
  output logic              busy,
  output logic              done,
  output logic              error
);

  state_t            state, state_n;
  logic              start_q;
  logic              start_rise;
  logic [7:0]        op, op_n;
  logic [1:0]        step, step_n;     // byte index within the current command
  logic [15:0]       cnt, cnt_n;       // repeat count or wait cycles
  logic [7:0]        tmp, tmp_n;       // first operand held for a later access
  logic [1:0]        wr_port, wr_port_n;
  logic [7:0]        wr_data, wr_data_n;
  logic [ROM_AW-1:0] rom_address_n;
  logic              busy_n, done_n, error_n;
  logic              go;
  logic              ready;

  assign start_rise = start & ~start_q;

  // Sequencer registers; enable freezes everything except the SDRAM wait
  always_ff @(posedge clk) begin
    if (!n_reset) begin
      state       <= S_SDRAM;
      start_q     <= 1'b1;     // a start held through reset is not an edge
      op          <= 8'd0;
      step        <= 2'd0;
      cnt         <= 16'd0;
      tmp         <= 8'd0;
      wr_port     <= 2'd0;
      wr_data     <= 8'd0;
      rom_address <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      error       <= 1'b0;
    end else if (enable || (state == S_SDRAM)) begin
      state       <= state_n;
      start_q     <= start;
      op          <= op_n;
      step        <= step_n;
      cnt         <= cnt_n;
      tmp         <= tmp_n;
      wr_port     <= wr_port_n;
      wr_data     <= wr_data_n;
      rom_address <= rom_address_n;
      busy        <= busy_n;
      done        <= done_n;
      error       <= error_n;
    end
  end

  // Fetch/decode: every byte goes FETCH -> CAPT, then decode picks the next move
  always_comb begin
    state_n       = state;
    op_n          = op;
    step_n        = step;
    cnt_n         = cnt;
    tmp_n         = tmp;
    wr_port_n     = wr_port;
    wr_data_n     = wr_data;
    rom_address_n = rom_address;
    busy_n        = busy;
    done_n        = done;
    error_n       = error;
    go            = 1'b0;
    case (state)
      S_SDRAM: begin
        if (!sdram_busy) state_n = S_IDLE;
      end
      S_IDLE: begin
        if (start_rise) begin
          rom_address_n = '0;
          busy_n        = 1'b1;
          done_n        = 1'b0;
          error_n       = 1'b0;
          step_n        = 2'd0;
          state_n       = S_FETCH;
        end
      end
      S_FETCH: state_n = S_CAPT;
      S_CAPT: begin
        if (rom_address == '1) begin
          error_n = 1'b1;
          busy_n  = 1'b0;
          state_n = S_IDLE;
        end else begin
          rom_address_n = rom_address + 1'b1;
          state_n       = S_FETCH;
          if (step == 2'd0) begin
            op_n   = rom_data;
            step_n = 2'd1;
            case (rom_data)
              OP_END: begin
                done_n  = 1'b1;
                busy_n  = 1'b0;
                state_n = S_IDLE;
              end
              OP_REG, OP_PAL, OP_ADDR, OP_DATA, OP_PORT, OP_WAIT: ;
              default: begin
                error_n = 1'b1;
                busy_n  = 1'b0;
                state_n = S_IDLE;
              end
            endcase
          end else begin
            case (op)
              OP_REG: begin
                if (step == 2'd1) begin
                  tmp_n  = rom_data;
                  step_n = 2'd2;
                end else begin
                  wr_port_n = VDP_PORT1;
                  wr_data_n = rom_data;
                  state_n   = S_WRITE;
                end
              end
              OP_ADDR: begin
                wr_port_n = VDP_PORT1;
                wr_data_n = (step == 2'd1) ? rom_data : {2'b01, rom_data[5:0]};
                state_n   = S_WRITE;
              end
              OP_PORT: begin
                if (step == 2'd1) begin
                  tmp_n  = rom_data;
                  step_n = 2'd2;
                end else begin
                  wr_port_n = tmp[1:0];
                  wr_data_n = rom_data;
                  state_n   = S_WRITE;
                end
              end
              OP_PAL: begin
                if (step == 2'd1) begin
                  cnt_n  = (rom_data == 8'd0) ? 16'd256 : {8'd0, rom_data};
                  step_n = 2'd2;
                end else begin
                  wr_port_n = VDP_PORT2;
                  wr_data_n = rom_data;
                  cnt_n     = cnt - 1'b1;
                  state_n   = S_WRITE;
                end
              end
              OP_DATA: begin
                if (step == 2'd1) begin
                  tmp_n  = rom_data;
                  step_n = 2'd2;
                end else if (step == 2'd2) begin
                  cnt_n  = {rom_data, tmp};
                  step_n = ({rom_data, tmp} == 16'd0) ? 2'd0 : 2'd3;
                end else begin
                  wr_port_n = VDP_PORT0;
                  wr_data_n = rom_data;
                  cnt_n     = cnt - 1'b1;
                  state_n   = S_WRITE;
                end
              end
              OP_WAIT: begin
                if (step == 2'd1) begin
                  tmp_n  = rom_data;
                  step_n = 2'd2;
                end else begin
                  cnt_n  = {rom_data, tmp};
                  step_n = 2'd0;
                  if ({rom_data, tmp} != 16'd0) state_n = S_WAIT;
                end
              end
              default: step_n = 2'd0;
            endcase
          end
        end
      end
      S_WRITE: begin
        go      = 1'b1;
        state_n = S_BUSW;
      end
      S_BUSW: begin
        if (ready) begin
          state_n = S_FETCH;
          step_n  = 2'd0;
          case (op)
            OP_REG: begin
              if (step == 2'd2) begin
                wr_data_n = {2'b10, tmp[5:0]};
                step_n    = 2'd3;
                state_n   = S_WRITE;
              end
            end
            OP_ADDR: if (step == 2'd1) step_n = 2'd2;
            OP_PAL:  if (cnt != 16'd0) step_n = 2'd2;
            OP_DATA: if (cnt != 16'd0) step_n = 2'd3;
            default: ;
          endcase
        end
      end
      S_WAIT: begin
        if ((cnt == 16'd1) || (cnt == 16'd0)) begin
          cnt_n   = 16'd0;
          step_n  = 2'd0;
          state_n = S_FETCH;
        end else begin
          cnt_n = cnt - 1'b1;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  vdp_bus_writer #(
    .GAP_W    (GAP_W),
    .REG_GAP  (REG_GAP),
    .DATA_GAP (DATA_GAP)
  ) u_writer (
    .clk     (clk),
    .n_reset (n_reset),
    .enable  (enable),
    .go      (go),
    .port    (wr_port),
    .data    (wr_data),
    .is_data (wr_port == VDP_PORT0),
    .ready   (ready),
    .bus     (bus)
  );

endmodule
`default_nettype wire

// File: tb/tb_vdp_script_player.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_vdp_script_player                                                 |
// | Directed and random scripts replayed against a byte-stream model of  |
// | the script language; bus slave with programmable ack latency.        |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_vdp_script_player;

  localparam int ROM_SIZE = 16384;
  localparam int RG       = 24;
  localparam int DG       = 4;
  localparam int BUDGET   = 12000;

  logic        clk, n_reset, start, enable, sdram_busy;
  logic [13:0] rom_address;
  logic [7:0]  rom_data;
  logic        busy, done, error;
  logic [7:0]  rom [0:ROM_SIZE-1];

  vdp_script_player_if bus_if ();

  vdp_script_player #(
    .ROM_AW(14), .GAP_W(10), .REG_GAP(RG), .DATA_GAP(DG)
  ) dut (
    .clk(clk), .n_reset(n_reset), .start(start), .enable(enable),
    .sdram_busy(sdram_busy), .bus(bus_if), .rom_address(rom_address),
    .rom_data(rom_data), .busy(busy), .done(done), .error(error)
  );

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // synchronous ROM, one cycle read latency
  always @(posedge clk) rom_data <= rom[rom_address];

  // bus slave: ack after ack_lat extra cycles, hold until req drops
  int   ack_lat = 2;
  int   lat_cnt = 0;
  bit   slave_hold = 0;
  logic ack_q = 1'b0;
  int   got_q[$];
  assign bus_if.ack = ack_q;

  always @(posedge clk) begin
    if (bus_if.req === 1'b0) begin
      ack_q   <= 1'b0;
      lat_cnt <= 0;
    end else if (bus_if.req === 1'b1 && !slave_hold && !ack_q) begin
      if (lat_cnt >= ack_lat) begin
        ack_q <= 1'b1;
        got_q.push_back({22'd0, bus_if.address, bus_if.wdata});
      end else begin
        lat_cnt <= lat_cnt + 1;
      end
    end
  end

  // watch every request: wr must accompany it, and the idle time before it
  // must cover the gap owed to the previous access's port
  int   req_rises = 0;
  int   idle = 0;
  bit   have_prev = 0;
  logic req_prev = 1'b0;
  logic [1:0] last_port = 2'd0;
  always @(negedge clk) begin
    if (n_reset) begin
      if (bus_if.req && !req_prev) begin
        req_rises++;
        check("wr_with_req", bus_if.wr, 1);
        if (have_prev)
          check("gap", (idle >= ((last_port == 2'd0) ? DG : RG)), 1);
        have_prev = 1;
        idle      = 0;
        last_port = bus_if.address;
      end
      if (!bus_if.req) idle++;
      req_prev = bus_if.req;
    end
  end

  // ---------------- reference model of the script language ----------------
  int exp_q[$];
  int m_a;
  bit m_ovf;
  bit e_done, e_err;

  function automatic int rd();
    if (m_ovf) return 0;
    if (m_a == ROM_SIZE - 1) begin
      m_ovf = 1;
      return 0;
    end
    m_a++;
    return int'(rom[m_a-1]);
  endfunction

  function automatic void push_exp(input int p, input int d);
    exp_q.push_back(p * 256 + d);
  endfunction

  task automatic model();
    int op, b1, b2, n;
    exp_q.delete();
    m_a = 0; m_ovf = 0; e_done = 0; e_err = 0;
    while (!e_done && !e_err) begin
      op = rd();
      if (m_ovf) break;
      case (op)
        0: e_done = 1;
        1: begin
          b1 = rd(); b2 = rd();
          if (!m_ovf) begin push_exp(1, b2); push_exp(1, 8'h80 | (b1 & 63)); end
        end
        2: begin
          n = rd();
          if (n == 0) n = 256;
          for (int i = 0; i < n && !m_ovf; i++) begin
            b1 = rd();
            if (!m_ovf) push_exp(2, b1);
          end
        end
        3: begin
          b1 = rd();
          if (!m_ovf) push_exp(1, b1);
          b2 = rd();
          if (!m_ovf) push_exp(1, 8'h40 | (b2 & 63));
        end
        4: begin
          b1 = rd(); b2 = rd();
          n = b2 * 256 + b1;
          for (int i = 0; i < n && !m_ovf; i++) begin
            b1 = rd();
            if (!m_ovf) push_exp(0, b1);
          end
        end
        5: begin
          b1 = rd(); b2 = rd();
          if (!m_ovf) push_exp(b1 & 3, b2);
        end
        6: begin b1 = rd(); b2 = rd(); end
        default: e_err = 1;
      endcase
    end
    if (m_ovf) e_err = 1;
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic clear_rom();
    for (int i = 0; i < ROM_SIZE; i++) rom[i] = 8'h00;
  endtask

  task automatic launch();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
  endtask

  task automatic recover();
    n_reset = 1'b0;
    enable  = 1'b1;
    slave_hold = 0;
    repeat (3) @(negedge clk);
    n_reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic finish_run(input string name);
    int cyc = 0;
    while (!(!busy && (done || error)) && cyc < BUDGET) begin
      @(negedge clk);
      cyc++;
    end
    check({name, "/timeout"}, (cyc < BUDGET), 1);
    if (cyc >= BUDGET) recover();
    check({name, "/done"}, done, e_done);
    check({name, "/error"}, error, e_err);
    check({name, "/busy"}, busy, 0);
    check({name, "/rom_address"}, rom_address, m_a);
    check({name, "/nwrites"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      check({name, "/write"}, got_q[i], exp_q[i]);
  endtask

  task automatic run_script(input string name, input int lat);
    model();
    ack_lat = lat;
    got_q.delete();
    launch();
    finish_run(name);
  endtask

  task automatic gen_script();
    int a = 0;
    int ncmd, kind, n;
    clear_rom();
    ncmd = $urandom_range(2, 6);
    for (int c = 0; c < ncmd; c++) begin
      kind = $urandom_range(0, 7);
      case (kind)
        1: begin
          n = $urandom_range(1, 4);
          rom[a] = 8'h02; rom[a+1] = 8'(n); a += 2;
          for (int i = 0; i < n; i++) begin rom[a] = 8'($urandom); a++; end
        end
        2: begin rom[a] = 8'h03; rom[a+1] = 8'($urandom); rom[a+2] = 8'($urandom); a += 3; end
        3: begin
          n = $urandom_range(0, 4);
          rom[a] = 8'h04; rom[a+1] = 8'(n); rom[a+2] = 8'h00; a += 3;
          for (int i = 0; i < n; i++) begin rom[a] = 8'($urandom); a++; end
        end
        4: begin rom[a] = 8'h05; rom[a+1] = 8'($urandom); rom[a+2] = 8'($urandom); a += 3; end
        5: begin rom[a] = 8'h06; rom[a+1] = 8'($urandom_range(0, 20)); rom[a+2] = 8'h00; a += 3; end
        6: begin rom[a] = 8'($urandom_range(7, 255)); a++; end
        default: begin rom[a] = 8'h01; rom[a+1] = 8'($urandom); rom[a+2] = 8'($urandom); a += 3; end
      endcase
    end
    rom[a] = 8'h00;
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int rises0, cyc;
    bit changed;
    logic [31:0] snap;

    n_reset = 1'b0; start = 1'b1; enable = 1'b1; sdram_busy = 1'b1;
    clear_rom();
    repeat (5) @(negedge clk);
    check("rst/req", bus_if.req, 0);
    check("rst/wr", bus_if.wr, 0);
    check("rst/address", bus_if.address, 0);
    check("rst/wdata", bus_if.wdata, 0);
    check("rst/rom_address", rom_address, 0);
    check("rst/busy", busy, 0);
    check("rst/done", done, 0);
    check("rst/error", error, 0);

    // held in SDRAM wait with start toggling; start left high at release
    rom[0] = 8'h05; rom[1] = 8'h01; rom[2] = 8'h11;
    n_reset = 1'b1;
    rises0 = req_rises;
    repeat (20) @(negedge clk);
    start = 1'b0;
    repeat (20) @(negedge clk);
    start = 1'b1;
    repeat (20) @(negedge clk);
    start = 1'b0;
    repeat (20) @(negedge clk);
    start = 1'b1;
    repeat (20) @(negedge clk);
    check("sdram/busy", busy, 0);
    sdram_busy = 1'b0;
    repeat (10) @(negedge clk);
    check("sdram/no_launch", busy, 0);
    check("sdram/no_req", req_rises - rises0, 0);
    start = 1'b0;
    @(negedge clk);

    // REG
    clear_rom();
    rom[0] = 8'h01; rom[1] = 8'h07; rom[2] = 8'hF7; rom[3] = 8'h00;
    run_script("reg", 2);

    // ADDR + DATA, with a start edge mid-run that must be ignored
    clear_rom();
    rom[0] = 8'h03; rom[1] = 8'h00; rom[2] = 8'h00; rom[3] = 8'h04; rom[4] = 8'h03;
    rom[5] = 8'h00; rom[6] = 8'hAA; rom[7] = 8'hBB; rom[8] = 8'hCC; rom[9] = 8'h00;
    model();
    ack_lat = 1;
    got_q.delete();
    launch();
    repeat (20) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    finish_run("addr_data");

    // palette of 256 entries, next opcode at 258
    clear_rom();
    rom[0] = 8'h02; rom[1] = 8'h00;
    for (int i = 0; i < 256; i++) rom[2+i] = 8'($urandom);
    rom[258] = 8'h00;
    run_script("pal256", 0);

    // illegal opcode, then a restart with a good script
    clear_rom();
    rom[0] = 8'h07;
    rises0 = req_rises;
    run_script("illegal", 1);
    check("illegal/no_req", req_rises - rises0, 0);
    rom[0] = 8'h05; rom[1] = 8'h02; rom[2] = 8'h5A; rom[3] = 8'h00;
    model();
    got_q.delete();
    launch();
    check("restart/error_clr", error, 0);
    check("restart/busy", busy, 1);
    check("restart/rom_address", rom_address, 0);
    finish_run("restart");

    // freeze in the middle of a pending request
    clear_rom();
    rom[0] = 8'h04; rom[1] = 8'h03; rom[2] = 8'h00;
    rom[3] = 8'h11; rom[4] = 8'h22; rom[5] = 8'h33; rom[6] = 8'h00;
    model();
    ack_lat = 12;
    got_q.delete();
    launch();
    cyc = 0;
    while (!(bus_if.req && !bus_if.ack && got_q.size() == 1) && cyc < 2000) begin
      @(negedge clk);
      cyc++;
    end
    check("freeze/reach", (cyc < 2000), 1);
    enable = 1'b0;
    slave_hold = 1;
    snap = {15'd0, bus_if.req, bus_if.address, bus_if.wdata, rom_address[5:0]};
    changed = 0;
    repeat (50) begin
      @(negedge clk);
      if (snap !== {15'd0, bus_if.req, bus_if.address, bus_if.wdata, rom_address[5:0]})
        changed = 1;
    end
    check("freeze/hold", changed, 0);
    check("freeze/req", bus_if.req, 1);
    enable = 1'b1;
    slave_hold = 0;
    finish_run("freeze");

    // random scripts
    for (int t = 0; t < 8; t++) begin
      gen_script();
      run_script("rand", $urandom_range(0, 4));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
